// File: rtl/hub75_fb_arbiter_if.sv
// Client/RAM-side signal bundle for hub75_fb_arbiter.
// The master modport is the arbiter; the slave modport is the client/RAM side.
interface hub75_fb_arbiter_if #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 16
);
  logic                  rd_pending;
  logic                  rd_boot;
  logic                  rd_active;
  logic                  rd_done;
  logic [ADDR_WIDTH-1:0] rd_fb_addr;
  logic                  rd_fb_rden;
  logic                  wi_pending;
  logic                  wi_boot;
  logic                  wi_active;
  logic                  wi_done;
  logic [ADDR_WIDTH-1:0] wi_fb_addr;
  logic [DATA_WIDTH-1:0] wi_fb_data;
  logic                  wi_fb_wren;
  logic [ADDR_WIDTH-1:0] fb_addr;
  logic [DATA_WIDTH-1:0] fb_wdata;
  logic                  fb_wren;
  logic                  fb_rden;
  logic                  busy;

  modport master (
    input  rd_pending, rd_done, rd_fb_addr, rd_fb_rden,
    input  wi_pending, wi_done, wi_fb_addr, wi_fb_data, wi_fb_wren,
    output rd_boot, rd_active, wi_boot, wi_active,
    output fb_addr, fb_wdata, fb_wren, fb_rden, busy
  );

  modport slave (
    output rd_pending, rd_done, rd_fb_addr, rd_fb_rden,
    output wi_pending, wi_done, wi_fb_addr, wi_fb_data, wi_fb_wren,
    input  rd_boot, rd_active, wi_boot, wi_active,
    input  fb_addr, fb_wdata, fb_wren, fb_rden, busy
  );
endinterface

// File: rtl/hub75_fb_arbiter.sv
// Shares the single-port HUB75 frame buffer between read-out and write-in with a
// boot/active/done handshake. Define HUB75_FB_FAIRNESS_EN to bound read-out streaks.
module hub75_fb_arbiter #(
  parameter int ADDR_WIDTH   = 13,
  parameter int DATA_WIDTH   = 16,
  parameter int MAX_RD_BURST = 4
) (
  input logic                clk,
  input logic                rst_n,
  hub75_fb_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, BOOT, ACTIVE, DRAIN} state_t;

  state_t state, state_nxt;
  logic   owner, owner_nxt;
  logic   first, first_nxt;
  logic   grant;
  logic   force_wi;
  logic   done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= 1'b0;
      first <= 1'b0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      first <= first_nxt;
    end
  end

`ifdef HUB75_FB_FAIRNESS_EN
  localparam int STREAK_W = $clog2(MAX_RD_BURST + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_RD_BURST);

  logic [STREAK_W-1:0] streak;

  assign force_wi = (streak == STREAK_MAX) && bus.wi_pending;

  // Only read-out grants that made write-in wait extend the streak.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak <= '0;
    end else if (grant) begin
      if (owner_nxt || !bus.wi_pending) streak <= '0;
      else if (streak != STREAK_MAX)    streak <= streak + 1'b1;
    end
  end
`else
  // Strict read-out priority: the comparison is constant false.
  assign force_wi = (MAX_RD_BURST < 0);
`endif

  assign done = owner ? bus.wi_done : bus.rd_done;

  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner;
    first_nxt     = 1'b0;
    grant         = 1'b0;
    bus.rd_boot   = 1'b0;
    bus.rd_active = 1'b0;
    bus.wi_boot   = 1'b0;
    bus.wi_active = 1'b0;
    bus.fb_addr   = '0;
    bus.fb_wdata  = '0;
    bus.fb_wren   = 1'b0;
    bus.fb_rden   = 1'b0;
    bus.busy      = (state != IDLE);

    case (state)
      IDLE: begin
        if (bus.rd_pending && !force_wi) begin
          state_nxt = BOOT;
          owner_nxt = 1'b0;
          grant     = 1'b1;
        end else if (bus.wi_pending) begin
          state_nxt = BOOT;
          owner_nxt = 1'b1;
          grant     = 1'b1;
        end
      end
      BOOT: begin
        state_nxt = ACTIVE;
        first_nxt = 1'b1;
      end
      ACTIVE: begin
        // A done left over from the client's previous run is ignored.
        if (!first && done) state_nxt = DRAIN;
      end
      DRAIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    bus.rd_boot   = (state == BOOT)   && !owner;
    bus.wi_boot   = (state == BOOT)   &&  owner;
    bus.rd_active = (state == ACTIVE) && !owner;
    bus.wi_active = (state == ACTIVE) &&  owner;

    // DRAIN keeps the mux on the owner so a late registered write can land.
    if (state != IDLE) begin
      bus.fb_addr  = owner ? bus.wi_fb_addr : bus.rd_fb_addr;
      bus.fb_wdata = owner ? bus.wi_fb_data : '0;
      bus.fb_wren  = owner & bus.wi_fb_wren;
      bus.fb_rden  = ~owner & bus.rd_fb_rden;
    end
  end

endmodule

// File: tb/tb_hub75_fb_arbiter.sv
// Directed bench for hub75_fb_arbiter: reset, write-in run, collision/fairness,
// write-in isolation and mid-grant asynchronous reset.
module tb_hub75_fb_arbiter;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  hub75_fb_arbiter_if #(.ADDR_WIDTH(13), .DATA_WIDTH(16)) bus ();

  hub75_fb_arbiter #(
    .ADDR_WIDTH  (13),
    .DATA_WIDTH  (16),
    .MAX_RD_BURST(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [5:0] exp_wi;
    logic       e;
    n_chk  = 0;
    n_pass = 0;
    rst_n           = 1'b0;
    bus.rd_pending  = 1'b0;
    bus.rd_done     = 1'b0;
    bus.rd_fb_addr  = '0;
    bus.rd_fb_rden  = 1'b0;
    bus.wi_pending  = 1'b0;
    bus.wi_done     = 1'b0;
    bus.wi_fb_addr  = '0;
    bus.wi_fb_data  = '0;
    bus.wi_fb_wren  = 1'b0;
    tick();
    tick();
    chk("rst_busy",    bus.busy, 0);
    chk("rst_boot",    {bus.rd_boot, bus.wi_boot}, 0);
    chk("rst_active",  {bus.rd_active, bus.wi_active}, 0);
    chk("rst_fb_addr", bus.fb_addr, 0);
    chk("rst_fb_wd",   bus.fb_wdata, 0);
    chk("rst_fb_en",   {bus.fb_wren, bus.fb_rden}, 0);

    // Write-in run with a stale done flag
    rst_n          = 1'b1;
    bus.wi_pending = 1'b1;
    bus.wi_done    = 1'b1;
    tick();
    chk("wi_boot",       bus.wi_boot, 1);
    chk("wi_boot_act",   bus.wi_active, 0);
    chk("wi_boot_rd",    bus.rd_boot, 0);
    chk("wi_boot_busy",  bus.busy, 1);
    bus.wi_pending = 1'b0;
    tick();
    chk("wi_act1",       bus.wi_active, 1);
    chk("wi_act1_boot",  bus.wi_boot, 0);
    bus.wi_done = 1'b0;
    tick();
    chk("wi_act2_stale", bus.wi_active, 1);
    bus.wi_fb_addr = 13'h0123;
    bus.wi_fb_data = 16'hBEEF;
    bus.rd_fb_rden = 1'b1;
    bus.rd_fb_addr = 13'h1FFF;
    #1;
    chk("iso_addr",  bus.fb_addr, 13'h0123);
    chk("iso_wdata", bus.fb_wdata, 16'hBEEF);
    chk("iso_rden",  bus.fb_rden, 0);
    chk("iso_wren",  bus.fb_wren, 0);
    bus.rd_fb_rden = 1'b0;
    bus.rd_fb_addr = '0;
    #1;
    chk("iso_addr2", bus.fb_addr, 13'h0123);
    for (int i = 0; i < 128; i++) tick();
    chk("wi_act130", bus.wi_active, 1);
    bus.wi_done = 1'b1;
    tick();
    chk("wi_drain_act",  bus.wi_active, 0);
    chk("wi_drain_busy", bus.busy, 1);
    bus.wi_done    = 1'b0;
    bus.wi_fb_wren = 1'b1;
    bus.wi_fb_addr = 13'h1ABC;
    bus.wi_fb_data = 16'h00F3;
    bus.rd_fb_rden = 1'b1;
    bus.rd_fb_addr = 13'h0555;
    #1;
    chk("drain_addr",  bus.fb_addr, 13'h1ABC);
    chk("drain_wdata", bus.fb_wdata, 16'h00F3);
    chk("drain_wren",  bus.fb_wren, 1);
    chk("drain_rden",  bus.fb_rden, 0);
    tick();
    chk("idle_busy", bus.busy, 0);
    chk("idle_fb",   {bus.fb_wren, bus.fb_rden, bus.fb_addr, bus.fb_wdata}, 0);
    bus.wi_fb_wren = 1'b0;
    bus.rd_fb_rden = 1'b0;
    bus.wi_fb_addr = '0;
    bus.wi_fb_data = '0;
    bus.rd_fb_addr = '0;

    // Collision and grant order with both requests held
`ifdef HUB75_FB_FAIRNESS_EN
    exp_wi = 6'b010000;
`else
    exp_wi = 6'b000000;
`endif
    bus.rd_pending = 1'b1;
    bus.wi_pending = 1'b1;
    bus.rd_done    = 1'b1;
    bus.wi_done    = 1'b1;
    tick();
    for (int g = 0; g < 6; g++) begin
      e = exp_wi[g];
      chk($sformatf("order%0d_rd_boot", g), bus.rd_boot, !e);
      chk($sformatf("order%0d_wi_boot", g), bus.wi_boot, e);
      tick();
      tick();
      chk($sformatf("order%0d_act2", g), e ? bus.wi_active : bus.rd_active, 1);
      tick();
      chk($sformatf("order%0d_drain", g), {bus.busy, bus.rd_active, bus.wi_active}, 3'b100);
      tick();
      chk($sformatf("order%0d_idle", g), bus.busy, 0);
      if (g == 5) begin
        bus.rd_pending = 1'b0;
        bus.wi_pending = 1'b0;
      end
      tick();
    end
    chk("order_end_idle", bus.busy, 0);

    // Mid-grant asynchronous reset
    bus.rd_done    = 1'b0;
    bus.wi_done    = 1'b0;
    bus.rd_pending = 1'b1;
    tick();
    chk("mr_boot", bus.rd_boot, 1);
    bus.rd_pending = 1'b0;
    tick();
    bus.rd_fb_rden = 1'b1;
    bus.rd_fb_addr = 13'h0AAA;
    #1;
    chk("mr_act",  bus.rd_active, 1);
    chk("mr_rden", bus.fb_rden, 1);
    chk("mr_addr", bus.fb_addr, 13'h0AAA);
    rst_n = 1'b0;
    #1;
    chk("mr_rst_act",  bus.rd_active, 0);
    chk("mr_rst_rden", bus.fb_rden, 0);
    chk("mr_rst_addr", bus.fb_addr, 0);
    chk("mr_rst_busy", bus.busy, 0);
    tick();
    rst_n          = 1'b1;
    bus.rd_pending = 1'b1;
    tick();
    chk("mr_reboot",     bus.rd_boot, 1);
    chk("mr_reboot_act", bus.rd_active, 0);
    bus.rd_pending = 1'b0;
    tick();
    chk("mr_react", bus.rd_active, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
